// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: operation codes, ALU_Op encodings, funct7 constants and FSM state type.
package alu_ctrl_pkg;
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_OR   = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_LUI  = 5'b00100;
  localparam logic [4:0] OP_SLL  = 5'b00101;
  localparam logic [4:0] OP_SRL  = 5'b00110;
  localparam logic [4:0] OP_XOR  = 5'b00111;
  localparam logic [4:0] OP_BEQ  = 5'b01000;
  localparam logic [4:0] OP_BNE  = 5'b01001;
  localparam logic [4:0] OP_BLT  = 5'b01010;
  localparam logic [4:0] OP_SRA  = 5'b01011;
  localparam logic [4:0] OP_SLT  = 5'b01100;
  localparam logic [4:0] OP_SLTU = 5'b01101;
  localparam logic [4:0] OP_BGE  = 5'b01110;
  localparam logic [4:0] OP_BLTU = 5'b01111;
  localparam logic [4:0] OP_BGEU = 5'b11000;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;
  localparam logic [4:0] OP_ILL  = 5'b11111;
  localparam logic [2:0] ALUOP_R      = 3'b000;
  localparam logic [2:0] ALUOP_I      = 3'b001;
  localparam logic [2:0] ALUOP_LUI    = 3'b010;
  localparam logic [2:0] ALUOP_JALR   = 3'b011;
  localparam logic [2:0] ALUOP_BRANCH = 3'b100;
  localparam logic [2:0] ALUOP_LOAD   = 3'b101;
  localparam logic [2:0] ALUOP_STORE  = 3'b110;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  typedef enum logic {ST_IDLE, ST_BUSY} state_e;
  function automatic logic [4:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational funct7/ALU_Op/funct3 decode into a 5-bit ALU operation.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int MULDIV_EN = 1
) (
  input  logic [6:0] funct7_i,
  input  logic [2:0] alu_op_i,
  input  logic [2:0] funct3_i,
  output logic [4:0] op_o,
  output logic       is_muldiv_o,
  output logic       is_div_o,
  output logic       illegal_o
);
  always_comb begin
    op_o = OP_ILL;
    is_muldiv_o = 1'b0;
    case (alu_op_i)
      ALUOP_R:
        if (funct7_i == F7_BASE) op_o = base_op(funct3_i);
        else if (funct7_i == F7_ALT && funct3_i == 3'b000) op_o = OP_SUB;
        else if (funct7_i == F7_ALT && funct3_i == 3'b101) op_o = OP_SRA;
        else if (MULDIV_EN != 0 && funct7_i == F7_MULDIV) begin
          op_o = {2'b10, funct3_i};
          is_muldiv_o = 1'b1;
        end
      ALUOP_I:
        if (funct3_i == 3'b001) op_o = funct7_i == F7_BASE ? OP_SLL : OP_ILL;
        else if (funct3_i == 3'b101) op_o = funct7_i == F7_BASE ? OP_SRL : funct7_i == F7_ALT ? OP_SRA : OP_ILL;
        else op_o = base_op(funct3_i);
      ALUOP_LUI:    op_o = OP_LUI;
      ALUOP_JALR:   op_o = funct3_i == 3'b000 ? OP_ADD : OP_ILL;
      ALUOP_BRANCH: op_o = funct3_i == 3'b000 ? OP_BEQ  : funct3_i == 3'b001 ? OP_BNE :
                           funct3_i == 3'b100 ? OP_BLT  : funct3_i == 3'b101 ? OP_BGE :
                           funct3_i == 3'b110 ? OP_BLTU : funct3_i == 3'b111 ? OP_BGEU : OP_ILL;
      ALUOP_LOAD:   op_o = funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101} ? OP_ADD : OP_ILL;
      ALUOP_STORE:  op_o = funct3_i inside {3'b000, 3'b001, 3'b010} ? OP_ADD : OP_ILL;
      default: ;
    endcase
  end
  // funct3[2] separates the divide/remainder group from the multiplies
  assign is_div_o = is_muldiv_o & funct3_i[2];
  assign illegal_o = op_o == OP_ILL;
endmodule

// File: rtl/alu_control_seq.sv
// alu_control_seq: registered ALU control decode with multi-cycle mul/div sequencing and stall.
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int MULDIV_EN = 1,
  parameter int MUL_LAT   = 4,
  parameter int DIV_LAT   = 34
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush_i,
  input  logic       valid_i,
  input  logic [6:0] funct7_i,
  input  logic [2:0] alu_op_i,
  input  logic [2:0] funct3_i,
  output logic       ready_o,
  output logic       valid_o,
  output logic [4:0] alu_operation_o,
  output logic       muldiv_start_o,
  output logic       stall_o,
  output logic       illegal_o
);
  if (MUL_LAT < 2 || MUL_LAT > 63 || DIV_LAT < 2 || DIV_LAT > 63) begin : g_bad_lat
    $error("alu_control_seq: MUL_LAT and DIV_LAT must lie in 2..63");
  end
  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);
  state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [4:0] op_q, op_d, dec_op;
  logic single_q, single_d, illegal_q, illegal_d, start_q, start_d;
  logic dec_muldiv, dec_div, dec_illegal, done, accept;
  alu_ctrl_decode #(.MULDIV_EN(MULDIV_EN)) u_decode (
    .funct7_i    (funct7_i),
    .alu_op_i    (alu_op_i),
    .funct3_i    (funct3_i),
    .op_o        (dec_op),
    .is_muldiv_o (dec_muldiv),
    .is_div_o    (dec_div),
    .illegal_o   (dec_illegal)
  );
  assign done = state_q == ST_BUSY && cnt_q == 6'd0;
  assign ready_o = state_q == ST_IDLE || done;
  assign accept = valid_i & ~flush_i & ready_o;
  always_comb begin
    state_d = flush_i ? ST_IDLE : accept ? (dec_muldiv ? ST_BUSY : ST_IDLE) : done ? ST_IDLE : state_q;
    cnt_d = flush_i ? 6'd0 : accept && dec_muldiv ? (dec_div ? DIV_CNT : MUL_CNT) :
            cnt_q != 6'd0 ? cnt_q - 6'd1 : 6'd0;
    op_d = accept ? dec_op : op_q;
    single_d = accept & ~dec_muldiv;
    illegal_d = accept & dec_illegal;
    start_d = accept & dec_muldiv;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q <= 6'd0;
      op_q <= OP_ADD;
      single_q <= 1'b0;
      illegal_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      single_q <= single_d;
      illegal_q <= illegal_d;
      start_q <= start_d;
    end
  // a flush in the completion cycle aborts that result
  assign valid_o = (single_q | done) & ~flush_i;
  assign illegal_o = illegal_q & ~flush_i;
  assign stall_o = state_q == ST_BUSY && cnt_q != 6'd0;
  assign muldiv_start_o = start_q;
  assign alu_operation_o = op_q;
endmodule

// File: tb/tb_alu_control_seq.sv
// tb_alu_control_seq: directed plus random checks of two instances against a cycle-count model.
module tb_alu_control_seq;
  logic clk = 1'b0, reset = 1'b0, flush = 1'b0, valid = 1'b0;
  logic [6:0] f7 = '0;
  logic [2:0] aop = '0, f3 = '0;
  logic [1:0] ready, vout, start, stall, ill;
  logic [4:0] op [2];
  int checks = 0, errors = 0;
  int rem [2];
  logic [4:0] mop [2];
  logic pulse [2], mill [2], mstart [2];

  alu_control_seq #(.MULDIV_EN(1), .MUL_LAT(4), .DIV_LAT(34)) dut (
    .clk(clk), .reset(reset), .flush_i(flush), .valid_i(valid), .funct7_i(f7), .alu_op_i(aop),
    .funct3_i(f3), .ready_o(ready[0]), .valid_o(vout[0]), .alu_operation_o(op[0]),
    .muldiv_start_o(start[0]), .stall_o(stall[0]), .illegal_o(ill[0]));
  alu_control_seq #(.MULDIV_EN(0), .MUL_LAT(4), .DIV_LAT(34)) dut0 (
    .clk(clk), .reset(reset), .flush_i(flush), .valid_i(valid), .funct7_i(f7), .alu_op_i(aop),
    .funct3_i(f3), .ready_o(ready[1]), .valid_o(vout[1]), .alu_operation_o(op[1]),
    .muldiv_start_o(start[1]), .stall_o(stall[1]), .illegal_o(ill[1]));

  always #5 clk = ~clk;

  function automatic logic [5:0] ref_dec(bit men, logic [6:0] a7, logic [2:0] ao, logic [2:0] a3);
    logic [4:0] base [8] = '{5'b00000, 5'b00101, 5'b01100, 5'b01101, 5'b00111, 5'b00110, 5'b00010, 5'b00011};
    logic [4:0] br [8] = '{5'b01000, 5'b01001, 5'b11111, 5'b11111, 5'b01010, 5'b01110, 5'b01111, 5'b11000};
    case (ao)
      3'd0: begin
        if (a7 == 7'h00) return {1'b0, base[a3]};
        if (a7 == 7'h20 && a3 == 3'd0) return 6'b000001;
        if (a7 == 7'h20 && a3 == 3'd5) return 6'b001011;
        if (a7 == 7'h01 && men) return {3'b110, a3};
        return 6'b011111;
      end
      3'd1: begin
        if (a3 == 3'd1) return a7 == 7'h00 ? 6'b000101 : 6'b011111;
        if (a3 == 3'd5) return a7 == 7'h00 ? 6'b000110 : a7 == 7'h20 ? 6'b001011 : 6'b011111;
        return {1'b0, base[a3]};
      end
      3'd2: return 6'b000100;
      3'd3: return a3 == 3'd0 ? 6'b000000 : 6'b011111;
      3'd4: return {1'b0, br[a3]};
      3'd5: return (a3 <= 3'd2 || a3 == 3'd4 || a3 == 3'd5) ? 6'b000000 : 6'b011111;
      3'd6: return a3 <= 3'd2 ? 6'b000000 : 6'b011111;
      default: return 6'b011111;
    endcase
  endfunction

  task automatic chk(string tag, logic [4:0] obs, logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; mop[k] = '0; pulse[k] = 1'b0; mill[k] = 1'b0; mstart[k] = 1'b0;
    end
  endtask

  task automatic step(bit v, logic [6:0] a7, logic [2:0] ao, logic [2:0] a3, bit fl);
    logic [5:0] d;
    valid = v; f7 = a7; aop = ao; f3 = a3; flush = fl;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ready[%0d]", k), {4'b0, ready[k]}, {4'b0, rem[k] <= 1});
      chk($sformatf("valid[%0d]", k), {4'b0, vout[k]}, {4'b0, (pulse[k] || rem[k] == 1) && !fl});
      chk($sformatf("illegal[%0d]", k), {4'b0, ill[k]}, {4'b0, mill[k] && !fl});
      chk($sformatf("stall[%0d]", k), {4'b0, stall[k]}, {4'b0, rem[k] > 1});
      chk($sformatf("start[%0d]", k), {4'b0, start[k]}, {4'b0, mstart[k]});
      chk($sformatf("op[%0d]", k), op[k], mop[k]);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      d = ref_dec(k == 0, a7, ao, a3);
      if (fl) begin
        rem[k] = 0; pulse[k] = 1'b0; mill[k] = 1'b0; mstart[k] = 1'b0;
      end else if (v && rem[k] <= 1) begin
        mop[k] = d[4:0];
        rem[k] = d[5] ? (a3[2] ? 34 : 4) : 0;
        pulse[k] = !d[5]; mill[k] = d[4:0] == 5'b11111; mstart[k] = d[5];
      end else begin
        rem[k] = rem[k] > 0 ? rem[k] - 1 : 0;
        pulse[k] = 1'b0; mill[k] = 1'b0; mstart[k] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 7'h00, 3'd0, 3'd0, 0);
  endtask

  initial begin
    logic [6:0] r7;
    model_reset();
    #7 reset = 1'b1;
    idle(1);
    step(1, 7'h20, 3'd0, 3'd0, 0);
    idle(2);
    step(1, 7'h01, 3'd0, 3'd0, 0);
    idle(5);
    step(1, 7'h01, 3'd0, 3'd5, 0);
    idle(10);
    step(0, 7'h00, 3'd0, 3'd0, 1);
    idle(1);
    step(1, 7'h00, 3'd0, 3'd3, 0);
    idle(1);
    step(1, 7'h00, 3'd2, 3'd0, 0);
    step(1, 7'h00, 3'd4, 3'd7, 0);
    step(1, 7'h00, 3'd5, 3'd2, 0);
    idle(1);
    step(1, 7'h01, 3'd0, 3'd0, 0);
    step(1, 7'h00, 3'd7, 3'd0, 0);
    idle(4);
    step(1, 7'h01, 3'd0, 3'd4, 0);
    idle(5);
    #2 reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", {4'b0, ready[k]}, 5'd1);
      chk("rst_valid", {4'b0, vout[k]}, 5'd0);
      chk("rst_op", op[k], 5'd0);
      chk("rst_start", {4'b0, start[k]}, 5'd0);
      chk("rst_stall", {4'b0, stall[k]}, 5'd0);
      chk("rst_illegal", {4'b0, ill[k]}, 5'd0);
    end
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    step(1, 7'h00, 3'd0, 3'd7, 0);
    idle(1);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(3))
        0: r7 = 7'h00;
        1: r7 = 7'h20;
        2: r7 = 7'h01;
        default: r7 = 7'($urandom);
      endcase
      step($urandom_range(9) < 7, r7, 3'($urandom), 3'($urandom), $urandom_range(24) == 0);
    end
    idle(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_control_seq.md
# alu_control_seq

Parametrised, registered successor to the single-cycle ALU control decoder. It decodes full funct7, ALU_Op and funct3 into a 5-bit ALU operation code covering the base RV32I ALU/branch set plus the M extension. It sequences multi-cycle multiply/divide operations with a ready/valid handshake and a pipeline stall. It sits between the main control unit and the ALU/mul-div datapath.

## Interface
Parameters:
- MULDIV_EN, 1, 1 enables M-extension decode; 0 makes every M op illegal.
- MUL_LAT, 4, cycles from accept to result for MUL/MULH/MULHSU/MULHU; range 2..63.
- DIV_LAT, 34, cycles from accept to result for DIV/DIVU/REM/REMU; range 2..63.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous abort of any in-flight operation.
- valid_i  in  1  new decode request.
- funct7_i  in  7  instruction funct7.
- alu_op_i  in  3  ALU_Op from the control unit.
- funct3_i  in  3  instruction funct3.
- ready_o  out  1  request can be accepted this cycle.
- valid_o  out  1  one-cycle pulse: alu_operation_o is final.
- alu_operation_o  out  5  operation code to the ALU.
- muldiv_start_o  out  1  one-cycle start pulse to the mul/div unit.
- stall_o  out  1  pipeline hold while a multi-cycle op runs.
- illegal_o  out  1  pulses with valid_o when the encoding is undefined.

## Operation
- Decode by ALU_Op:
  - 000 R-type: funct7 0000000 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by funct3. 0100000 with funct3 000/101 selects SUB/SRA. 0000001 selects M ops by funct3 when MULDIV_EN=1. Anything else is illegal.
  - 001 I-type: same funct3 map without SUB. SLLI/SRLI need funct7=0000000, SRAI needs 0100000. Other shift funct7 values are illegal.
  - 010 LUI → LUI, funct7/funct3 ignored. 011 JALR: funct3 000 → ADD.
  - 100 branch: funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 010/011 illegal.
  - 101 load and 110 store: funct3 000/001/010/100/101 (store: 000/001/010) → ADD.
  - 111 is illegal.
- Codes: ADD 00000, SUB 00001, OR 00010, AND 00011, LUI 00100, SLL 00101, SRL 00110, XOR 00111, BEQ 01000, BNE 01001, BLT 01010, SRA 01011, SLT 01100, SLTU 01101, BGE 01110, BLTU 01111, BGEU 11000.
- M codes: MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.
- Illegal → 11111 with illegal_o=1, handled as a single-cycle op.
- FSM has two states:
  - IDLE: ready_o=1. Accept on valid_i & ~flush_i. A single-cycle op stays in IDLE. An M op goes to BUSY with cnt=LAT-1.
  - BUSY: ready_o=0, stall_o=1. cnt decrements each cycle. At cnt==0, valid_o=1, ready_o=1, stall_o=0; next state is IDLE, or a new accept.
- alu_operation_o is registered at accept and held until the next accept.
- flush_i has priority: it forces IDLE and suppresses valid_o/illegal_o for the aborted op. valid_i in the same cycle is not accepted. alu_operation_o is unchanged.

## Timing
- Reset values: ready_o=1, valid_o=0, alu_operation_o=00000, muldiv_start_o=0, stall_o=0, illegal_o=0, state IDLE, cnt=0.
- Accept happens at edge E; cycle t is the cycle after E.
- Single-cycle op: valid_o=1 in cycle t, latency 1. Back-to-back accepts every cycle give valid_o on every cycle.
- Multi-cycle op with latency L:
  - muldiv_start_o=1 in cycle t only.
  - stall_o=1 in cycles t..t+L-2.
  - valid_o=1 in cycle t+L-1.
  - ready_o=0 in t..t+L-2 and high in t+L-1, so the next op is accepted at the edge ending t+L-1.
- Reset asserted mid-operation returns all outputs to reset values immediately, without waiting for clk.
- The counter is 6 bits wide. LAT values outside 2..63 are a parameter error and are rejected by an elaboration check.

## Structure
- Package alu_ctrl_pkg holds:
  - all 5-bit operation codes;
  - ALU_Op encodings (R, I, LUI, JALR, BRANCH, LOAD, STORE);
  - the funct7 constants 0000000, 0100000 and 0000001;
  - the FSM state type.
- Sub-module alu_ctrl_decode is purely combinational (funct7, ALU_Op, funct3, MULDIV_EN → op, is_muldiv, is_div, illegal). alu_control_seq instantiates it and adds the FSM, counter and output registers.

## Test plan
- Reset release, then valid_i with ALU_Op=000, funct7=0100000, funct3=000 → next cycle valid_o=1, alu_operation_o=00001 (SUB), ready_o stays 1.
- MUL request (funct7=0000001, ALU_Op=000, funct3=000), MUL_LAT=4 → muldiv_start_o in cycle t, stall_o in t..t+2, valid_o with 10000 in t+3.
- DIVU, DIV_LAT=34: assert flush_i at t+10 → no valid_o. IDLE and ready_o=1 the following cycle. A SLTU request then completes with 01101.
- Back-to-back LUI, BGEU, load funct3=010 on consecutive cycles → valid_o continuous; codes 00100, 11000, 00000.
- MULDIV_EN=0 with a MUL request, and ALU_Op=111 → 11111 with illegal_o=1, single-cycle each, stall_o never asserted.
- Reset pulled low in the middle of a DIV → every output is at its reset value within the same cycle. The first request after release is accepted normally.
